// File: rtl/fir_coef_loader.sv
// fir_coef_loader: writes 16-bit FIR coefficients into per-filter coefficient RAMs.
// Each MSB-write strobe assembles {msb,lsb} and writes it at an auto-incrementing tap
// address of the selected filter. Load progress is tracked against num_of_coef.
// Optional feature macro: COEF_CHECKSUM_EN (adds coef_checksum running sum output).
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   coef_wr_stb           one-cycle strobe, MSB register just written
//   coef_select_reg       [FSEL_BITS-1:0] filter select, [7] restart pointer
//   coef_wr_*_data_reg    coefficient bytes
//   num_of_coef           coefficients per filter (0 = no load permitted)
//   coef_ram_we/addr/data coefficient RAM write port (one-hot enable)
//   coef_count            coefficients written since last pointer reset
//   load_done_stb         pulse when the last coefficient is written
//   coef_checksum         (COEF_CHECKSUM_EN only) modulo-2^16 sum of written data
//   coef_status           {done, overflow, busy, 3'b0, sel[1:0]}
module fir_coef_loader #(
    parameter int unsigned NUM_FILTERS    = 4,
    parameter int unsigned COEF_ADDR_BITS = 9,
    parameter int unsigned COEF_WIDTH     = 16,
    parameter int unsigned FSEL_BITS      = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      coef_wr_stb,
    input  logic [7:0]                coef_select_reg,
    input  logic [7:0]                coef_wr_lsb_data_reg,
    input  logic [7:0]                coef_wr_msb_data_reg,
    input  logic [COEF_ADDR_BITS-1:0] num_of_coef,
    output logic [NUM_FILTERS-1:0]    coef_ram_we,
    output logic [COEF_ADDR_BITS-1:0] coef_ram_addr,
    output logic [COEF_WIDTH-1:0]     coef_ram_data,
    output logic [COEF_ADDR_BITS-1:0] coef_count,
    output logic                      load_done_stb,
`ifdef COEF_CHECKSUM_EN
    output logic [15:0]               coef_checksum,
`endif
    output logic [7:0]                coef_status
);

    typedef enum logic [1:0] {StIdle, StCapture, StWrite, StAdvance} state_e;

    state_e                    state_q, state_d;
    logic [COEF_ADDR_BITS-1:0] ptr_q, ptr_d, count_q, count_d, addr_q, addr_d, ptr_eff;
    logic [FSEL_BITS-1:0]      last_sel_q, last_sel_d, sel_q, sel_d, pend_sel_q, pend_sel_d;
    logic                      restart_q, restart_d, pend_restart_q, pend_restart_d;
    logic [COEF_WIDTH-1:0]     data_q, data_d, pend_data_q, pend_data_d, ram_data_q, ram_data_d;
    logic                      pending_q, pending_d, done_q, done_d, ovf_q, ovf_d;
    logic                      consume_pend, clr_ptr;
    logic [1:0]                status_sel;
    logic                      unused_sel_bits;
`ifdef COEF_CHECKSUM_EN
    logic [15:0]               csum_q, csum_d;
`endif

    assign unused_sel_bits = ^coef_select_reg[6:FSEL_BITS];

    // A queued strobe is served as soon as the FSM is back at a decision point.
    assign consume_pend = pending_q && (state_q == StIdle || state_q == StAdvance);
    assign clr_ptr      = restart_q || (sel_q != last_sel_q);
    assign ptr_eff      = clr_ptr ? '0 : ptr_q;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        count_d        = count_q;
        addr_d         = addr_q;
        ram_data_d     = ram_data_q;
        last_sel_d     = last_sel_q;
        sel_d          = sel_q;
        restart_d      = restart_q;
        data_d         = data_q;
        pend_sel_d     = pend_sel_q;
        pend_restart_d = pend_restart_q;
        pend_data_d    = pend_data_q;
        pending_d      = consume_pend ? 1'b0 : pending_q;
        done_d         = done_q;
        ovf_d          = ovf_q;
        load_done_stb  = 1'b0;
`ifdef COEF_CHECKSUM_EN
        csum_d         = csum_q;
`endif

        case (state_q)
            StIdle: begin
                if (pending_q) begin
                    sel_d     = pend_sel_q;
                    restart_d = pend_restart_q;
                    data_d    = pend_data_q;
                    state_d   = StCapture;
                end else if (coef_wr_stb) begin
                    sel_d     = coef_select_reg[FSEL_BITS-1:0];
                    restart_d = coef_select_reg[7];
                    data_d    = {coef_wr_msb_data_reg, coef_wr_lsb_data_reg};
                    state_d   = StCapture;
                end
            end
            StCapture: begin
                if (clr_ptr) begin
                    ptr_d   = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
`ifdef COEF_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
                last_sel_d = sel_q;
                // Live num_of_coef compare; also rejects every load when it is 0.
                if (ptr_eff >= num_of_coef) begin
                    ovf_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    addr_d     = ptr_eff;
                    ram_data_d = data_q;
                    state_d    = StWrite;
                end
            end
            StWrite: state_d = StAdvance;
            StAdvance: begin
                ptr_d   = ptr_q + 1'b1;
                count_d = count_q + 1'b1;
`ifdef COEF_CHECKSUM_EN
                csum_d  = csum_q + 16'(ram_data_q);
`endif
                if (COEF_ADDR_BITS'(ptr_q + 1'b1) == num_of_coef) begin
                    load_done_stb = reset_n;
                    done_d        = 1'b1;
                end
                if (pending_q) begin
                    sel_d     = pend_sel_q;
                    restart_d = pend_restart_q;
                    data_d    = pend_data_q;
                    state_d   = StCapture;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Strobes not taken directly by IDLE go to the one-deep pending slot.
        // Evaluated last so a drop's overflow wins over a same-cycle clear.
        if (coef_wr_stb && !(state_q == StIdle && !pending_q)) begin
            if (pending_q && !consume_pend) begin
                ovf_d = 1'b1;
            end else begin
                pending_d      = 1'b1;
                pend_sel_d     = coef_select_reg[FSEL_BITS-1:0];
                pend_restart_d = coef_select_reg[7];
                pend_data_d    = {coef_wr_msb_data_reg, coef_wr_lsb_data_reg};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            ptr_q          <= '0;
            count_q        <= '0;
            addr_q         <= '0;
            ram_data_q     <= '0;
            last_sel_q     <= '0;
            sel_q          <= '0;
            restart_q      <= 1'b0;
            data_q         <= '0;
            pend_sel_q     <= '0;
            pend_restart_q <= 1'b0;
            pend_data_q    <= '0;
            pending_q      <= 1'b0;
            done_q         <= 1'b0;
            ovf_q          <= 1'b0;
`ifdef COEF_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            count_q        <= count_d;
            addr_q         <= addr_d;
            ram_data_q     <= ram_data_d;
            last_sel_q     <= last_sel_d;
            sel_q          <= sel_d;
            restart_q      <= restart_d;
            data_q         <= data_d;
            pend_sel_q     <= pend_sel_d;
            pend_restart_q <= pend_restart_d;
            pend_data_q    <= pend_data_d;
            pending_q      <= pending_d;
            done_q         <= done_d;
            ovf_q          <= ovf_d;
`ifdef COEF_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
        end
    end

    // Reset gates the enable combinationally so an aborted WRITE never reaches the RAM.
    assign coef_ram_we   = (reset_n && state_q == StWrite) ? (NUM_FILTERS'(1) << sel_q) : '0;
    assign coef_ram_addr = addr_q;
    assign coef_ram_data = ram_data_q;
    assign coef_count    = count_q;
    assign status_sel    = 2'(last_sel_q);
    assign coef_status   = {done_q, ovf_q, state_q != StIdle, 3'b000, status_sel};
`ifdef COEF_CHECKSUM_EN
    assign coef_checksum = csum_q;
`endif

endmodule

// File: tb/tb_fir_coef_loader.sv
module tb_fir_coef_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        coef_wr_stb = 1'b0;
    logic [7:0]  coef_select_reg = '0;
    logic [7:0]  coef_wr_lsb_data_reg = '0;
    logic [7:0]  coef_wr_msb_data_reg = '0;
    logic [8:0]  num_of_coef = '0;
    logic [3:0]  coef_ram_we;
    logic [8:0]  coef_ram_addr;
    logic [15:0] coef_ram_data;
    logic [8:0]  coef_count;
    logic        load_done_stb;
    logic [7:0]  coef_status;
`ifdef COEF_CHECKSUM_EN
    logic [15:0] coef_checksum;
`endif

    fir_coef_loader dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .coef_wr_stb          (coef_wr_stb),
        .coef_select_reg      (coef_select_reg),
        .coef_wr_lsb_data_reg (coef_wr_lsb_data_reg),
        .coef_wr_msb_data_reg (coef_wr_msb_data_reg),
        .num_of_coef          (num_of_coef),
        .coef_ram_we          (coef_ram_we),
        .coef_ram_addr        (coef_ram_addr),
        .coef_ram_data        (coef_ram_data),
        .coef_count           (coef_count),
        .load_done_stb        (load_done_stb),
`ifdef COEF_CHECKSUM_EN
        .coef_checksum        (coef_checksum),
`endif
        .coef_status          (coef_status)
    );

    always #5 clk = ~clk;

    typedef struct {int sel; int addr; int data;} wr_t;

    wr_t exp_q[$];
    int  wr_cyc[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  done_seen = 0;

    // Reference model: transaction-level view of the loader state.
    int m_num = 0, m_ptr = 0, m_count = 0, m_last = 0, m_csum = 0, m_done_cnt = 0;
    bit m_done = 0, m_ovf = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every write enable must match the oldest expected write.
    always @(negedge clk) begin
        if (coef_ram_we != '0) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_write_we", int'(coef_ram_we), 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_we", int'(coef_ram_we), 1 << e.sel);
                chk("write_addr", int'(coef_ram_addr), e.addr);
                chk("write_data", int'(coef_ram_data), e.data);
            end
        end
        if (load_done_stb) done_seen++;
    end

    task automatic model_apply(input int sel, input bit rst, input int data);
        if (rst || sel != m_last) begin
            m_ptr = 0; m_count = 0; m_done = 0; m_ovf = 0; m_csum = 0;
        end
        m_last = sel;
        if (m_ptr >= m_num) begin
            m_ovf = 1;
        end else begin
            exp_q.push_back('{sel, m_ptr, data});
            m_ptr++;
            m_count++;
            m_csum = (m_csum + data) & 16'hffff;
            if (m_ptr == m_num) begin
                m_done = 1;
                m_done_cnt++;
            end
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_count = 0; m_last = 0; m_csum = 0; m_done = 0; m_ovf = 0;
    endtask

    task automatic set_regs(input int sel, input bit rst, input logic [15:0] d);
        coef_select_reg      = {rst, 5'b0, 2'(sel)};
        coef_wr_lsb_data_reg = d[7:0];
        coef_wr_msb_data_reg = d[15:8];
    endtask

    task automatic set_num(input int n);
        num_of_coef = 9'(n);
        m_num = n;
    endtask

    task automatic drive(input int sel, input bit rst, input logic [15:0] d);
        @(posedge clk); #1;
        coef_wr_stb = 1'b1;
        set_regs(sel, rst, d);
        @(posedge clk); #1;
        coef_wr_stb = 1'b0;
    endtask

    task automatic send(input int sel, input bit rst, input logic [15:0] d);
        model_apply(sel, rst, int'(d));
        drive(sel, rst, d);
        repeat (6) @(posedge clk);
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        chk({tag, "_status"}, int'(coef_status),
            int'({m_done, m_ovf, 1'b0, 3'b000, 2'(m_last)}));
        chk({tag, "_count"}, int'(coef_count), m_count);
`ifdef COEF_CHECKSUM_EN
        chk({tag, "_checksum"}, int'(coef_checksum), m_csum);
`endif
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", int'(coef_ram_we), 0);
        chk("rst_addr", int'(coef_ram_addr), 0);
        chk("rst_data", int'(coef_ram_data), 0);
        chk("rst_count", int'(coef_count), 0);
        chk("rst_done_stb", int'(load_done_stb), 0);
        chk("rst_status", int'(coef_status), 0);
        reset_n = 1'b1;

        // Basic load into filter 2
        set_num(3);
        send(2, 1, 16'h1234);
        send(2, 0, 16'hABCD);
        send(2, 0, 16'h0001);
        check_status("basic");
        chk("basic_status_const", int'(coef_status), 8'h82);
        chk("basic_done_pulses", done_seen, 1);

        // Overflow after done, then restart
        send(2, 0, 16'h7777);
        check_status("ovf_after_done");
        chk("ovf_status_const", int'(coef_status), 8'hC2);
        send(2, 1, 16'h5555);
        check_status("restart");
        chk("restart_status_const", int'(coef_status), 8'h02);

        // Select change
        set_num(4);
        send(0, 0, 16'h1111);
        send(0, 0, 16'h2222);
        send(1, 0, 16'h3333);
        check_status("selchg");
        chk("selchg_count_const", int'(coef_count), 1);

        // Back-to-back strobes; third one is dropped
        set_num(8);
        wr_cyc.delete();
        @(posedge clk); #1;
        coef_wr_stb = 1'b1;
        set_regs(1, 1, 16'hA001);
        n = cyc;
        model_apply(1, 1, 16'hA001);
        @(posedge clk); #1;
        set_regs(1, 0, 16'hA002);
        model_apply(1, 0, 16'hA002);
        @(posedge clk); #1;
        set_regs(1, 0, 16'hA003);
        m_ovf = 1;
        @(posedge clk); #1;
        coef_wr_stb = 1'b0;
        repeat (10) @(posedge clk);
        chk("b2b_num_writes", wr_cyc.size(), 2);
        if (wr_cyc.size() >= 2) begin
            chk("b2b_first_latency", wr_cyc[0] - n, 2);
            chk("b2b_second_latency", wr_cyc[1] - n, 5);
        end
        check_status("b2b");

        // num_of_coef == 0
        set_num(0);
        send(3, 0, 16'hBEEF);
        check_status("num0");

        // Reset asserted during WRITE
        set_num(5);
        drive(0, 1, 16'hDEAD);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst_in_write_we", int'(coef_ram_we), 0);
        @(negedge clk);
        chk("post_rst_addr", int'(coef_ram_addr), 0);
        chk("post_rst_data", int'(coef_ram_data), 0);
        chk("post_rst_count", int'(coef_count), 0);
        chk("post_rst_status", int'(coef_status), 0);
        reset_n = 1'b1;
        model_reset();

`ifdef COEF_CHECKSUM_EN
        set_num(4);
        send(0, 1, 16'hFFFF);
        send(0, 0, 16'h0002);
        chk("csum_wrap", int'(coef_checksum), 16'h0001);
        send(0, 1, 16'h0000);
        chk("csum_restart", int'(coef_checksum), 0);
`endif

        // Randomized loads against the model
        set_num(4);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7) == 0) set_num($urandom_range(6));
            send($urandom_range(3), $urandom_range(3) == 0, 16'($urandom));
            check_status("rand");
        end

        repeat (8) @(posedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("done_pulse_total", done_seen, m_done_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_coef_loader.md
Name: fir_coef_loader

Overview:
Downstream consumer of the SPI register file's FIR coefficient registers. On each MSB-write strobe it assembles a 16-bit coefficient and writes it into the selected filter's coefficient RAM at an auto-incrementing tap address. It tracks load progress against the programmed coefficient count and reports busy, done and overflow through a status byte that the register file reads back as AUD_STATUS.

Parameters:
NUM_FILTERS, 4, number of FIR filters; one coefficient RAM write-enable each.
COEF_ADDR_BITS, 9, tap address width; max 511 coefficients per filter.
COEF_WIDTH, 16, coefficient width; must equal 16 ({msb,lsb}).
FSEL_BITS, 2, filter-select width, equal to clog2(NUM_FILTERS).

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
coef_wr_stb  in  1  one-cycle strobe; MSB register has just been written
coef_select_reg  in  8  [FSEL_BITS-1:0] filter select; [7] restart pointer
coef_wr_lsb_data_reg  in  8  coefficient low byte
coef_wr_msb_data_reg  in  8  coefficient high byte
num_of_coef  in  COEF_ADDR_BITS  coefficients per filter; 0 means no load permitted
coef_ram_we  out  NUM_FILTERS  one-hot write enable, one cycle
coef_ram_addr  out  COEF_ADDR_BITS  tap address
coef_ram_data  out  COEF_WIDTH  {msb,lsb}
coef_count  out  COEF_ADDR_BITS  coefficients written since last pointer reset
load_done_stb  out  1  one-cycle pulse when the last coefficient is written
coef_status  out  8  {done, overflow, busy, 3'b0, sel[1:0]}

Behaviour:
- Clock and reset: all state changes on posedge clk. Reset is synchronous (reset_n==0 sampled at posedge) and active-low.
- Reset values:
  - Outputs coef_ram_we, coef_ram_addr, coef_ram_data, coef_count, load_done_stb and all status bits reset to 0.
  - Internal ptr=0, last_sel=0, pending=0, FSM=IDLE.
  - Reset asserted in any state aborts the operation; no write enable is issued in that cycle.
- FSM states: IDLE, CAPTURE, WRITE, ADVANCE.
- IDLE: on coef_wr_stb (or pending==1), clear pending and go to CAPTURE. Register sel=coef_select_reg[FSEL_BITS-1:0], restart=coef_select_reg[7], data={msb,lsb}.
- CAPTURE:
  - If restart==1 or sel!=last_sel: ptr<=0, coef_count<=0, done<=0, overflow<=0.
  - last_sel<=sel.
  - Next, evaluate against the post-reset ptr. If ptr>=num_of_coef (this includes num_of_coef==0): overflow<=1, no write, go to IDLE. Otherwise go to WRITE.
- WRITE:
  - coef_ram_we[sel]=1 for exactly one cycle; coef_ram_addr=ptr; coef_ram_data=data.
  - Address and data are held stable from this cycle until the next write.
- ADVANCE:
  - ptr<=ptr+1, coef_count<=coef_count+1.
  - If ptr+1==num_of_coef: load_done_stb=1 for one cycle and done<=1.
  - Go to IDLE.
- Latency: strobe at cycle N produces write enable at N+2 and counter update at N+3.
- Busy = FSM!=IDLE.
- Strobe while busy: sets pending (one-deep) and captures the register values at that time.
  - A second strobe while pending is already set is dropped and sets overflow.
- After done: further strobes without a restart or a select change hit ptr>=num_of_coef, set overflow and do not write.
- num_of_coef changed mid-load: the compare always uses the live value. If it is lowered below ptr, the next strobe sets overflow. No retroactive done.
- ptr never wraps: at most 511 by the num_of_coef bound.
- Done and overflow are sticky. They are cleared only by reset, restart, or a select change.

Optional Feature:
COEF_CHECKSUM_EN
- Defined: adds output coef_checksum[15:0], a running modulo-2^16 sum of every coefficient written.
  - Updated in ADVANCE.
  - Cleared wherever ptr is cleared, and on reset.
  - Overflowed (unwritten) strokes do not contribute.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Basic load: reset; num_of_coef=3, sel=2 with bit7=1. Three strobes with data 0x1234 (bit7 cleared after the first), 0xABCD, 0x0001.
  - Required: coef_ram_we=4'b0100 at addrs 0,1,2 with those data.
  - Required: load_done_stb once, after the third write; coef_count=3; coef_status=8'h82.
- Overflow after done: continue from the previous scenario with a fourth strobe.
  - Required: no write enable; coef_status=8'hC2.
  - Then strobe with bit7=1, data 0x5555: write at addr 0; status overflow and done cleared.
- Select change: load 2 coefficients into filter 0 (num_of_coef=4), then switch sel=1 and strobe.
  - Required: write to filter 1 at addr 0; coef_count=1.
- Back-to-back strobes: strobes at cycles N and N+1 with distinct data.
  - Required: two writes at addrs 0,1, second write enable at N+5.
  - A third strobe at N+2 is dropped and sets overflow.
- Edge cases: num_of_coef=0 → strobe sets overflow, no write. Reset asserted in the WRITE cycle → coef_ram_we=0 that cycle and all outputs 0 next cycle.
- COEF_CHECKSUM_EN: load 0xFFFF, 0x0002 → coef_checksum=0x0001; restart clears it to 0.
